// File: rtl/gen_io_arb.sv
// Two-master arbiter (68K / Z80 bank window) in front of one shared I/O slave.
// All requester and slave inputs are registered once before the FSM acts on them.
module gen_io_arb #(
  parameter int FIXED_PRIO = 1,
  parameter int TMO        = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       M_SEL,
  input  logic [3:0] M_A,
  input  logic       M_RNW,
  input  logic [7:0] M_DI,
  output logic [7:0] M_DO,
  output logic       M_DTACK_N,
  input  logic       Z_SEL,
  input  logic [3:0] Z_A,
  input  logic       Z_RNW,
  input  logic [7:0] Z_DI,
  output logic [7:0] Z_DO,
  output logic       Z_DTACK_N,
  output logic       IO_SEL,
  output logic [3:0] IO_A,
  output logic       IO_RNW,
  output logic [7:0] IO_DI,
  input  logic [7:0] IO_DO,
  input  logic       IO_DTACK_N,
  output logic       TMO_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    RECOVER
  } state_t;

  state_t state;
  state_t state_nxt;

  logic       m_sel_q;
  logic [3:0] m_a_q;
  logic       m_rnw_q;
  logic [7:0] m_di_q;
  logic       z_sel_q;
  logic [3:0] z_a_q;
  logic       z_rnw_q;
  logic [7:0] z_di_q;
  logic       io_dtack_q;
  logic [7:0] io_do_q;

  logic       gnt_z;
  logic       last_z;
  logic [7:0] cnt;

  logic       sel_g;
  logic       pick_z;
  logic       tmo_hit;
  logic       ev_grant;
  logic       ev_finish;
  logic       ev_timed;
  logic       ev_abort;
  logic       ev_release;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      m_sel_q    <= 1'b0;
      m_a_q      <= '0;
      m_rnw_q    <= 1'b1;
      m_di_q     <= '0;
      z_sel_q    <= 1'b0;
      z_a_q      <= '0;
      z_rnw_q    <= 1'b1;
      z_di_q     <= '0;
      io_dtack_q <= 1'b1;
      io_do_q    <= '0;
    end else begin
      m_sel_q    <= M_SEL;
      m_a_q      <= M_A;
      m_rnw_q    <= M_RNW;
      m_di_q     <= M_DI;
      z_sel_q    <= Z_SEL;
      z_a_q      <= Z_A;
      z_rnw_q    <= Z_RNW;
      z_di_q     <= Z_DI;
      io_dtack_q <= IO_DTACK_N;
      io_do_q    <= IO_DO;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign sel_g   = gnt_z ? z_sel_q : m_sel_q;
  assign tmo_hit = int'(cnt) >= TMO;

  // On a tie, round-robin favours whoever was not served last
  always_comb begin
    pick_z = z_sel_q;
    if (m_sel_q && z_sel_q) begin
      pick_z = (FIXED_PRIO != 0) ? 1'b0 : !last_z;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m_sel_q || z_sel_q) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!sel_g) state_nxt = RECOVER;
        else if (!io_dtack_q || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        if (!sel_g) state_nxt = RECOVER;
      end
      RECOVER: begin
        if (io_dtack_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ev_grant   = 1'b0;
    ev_finish  = 1'b0;
    ev_timed   = 1'b0;
    ev_abort   = 1'b0;
    ev_release = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        ev_grant = m_sel_q || z_sel_q;
      end
      state == ACCESS: begin
        ev_abort  = !sel_g;
        ev_finish = sel_g && (!io_dtack_q || tmo_hit);
        ev_timed  = sel_g && io_dtack_q && tmo_hit;
      end
      state == DONE: begin
        ev_release = !sel_g;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IO_SEL    <= 1'b0;
      IO_A      <= '0;
      IO_RNW    <= 1'b1;
      IO_DI     <= '0;
      M_DTACK_N <= 1'b1;
      Z_DTACK_N <= 1'b1;
      M_DO      <= 8'hFF;
      Z_DO      <= 8'hFF;
      TMO_ERR   <= 1'b0;
      cnt       <= '0;
      gnt_z     <= 1'b0;
      last_z    <= 1'b1;
    end else begin
      TMO_ERR <= ev_timed;
      if (ev_grant) begin
        IO_SEL <= 1'b1;
        gnt_z  <= pick_z;
        last_z <= pick_z;
        IO_A   <= pick_z ? z_a_q : m_a_q;
        IO_RNW <= pick_z ? z_rnw_q : m_rnw_q;
        IO_DI  <= pick_z ? z_di_q : m_di_q;
        cnt    <= '0;
      end else if (state == ACCESS && CE && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (ev_finish || ev_abort) begin
        IO_SEL <= 1'b0;
      end
      if (ev_finish) begin
        if (gnt_z) begin
          Z_DTACK_N <= 1'b0;
          if (IO_RNW) Z_DO <= ev_timed ? 8'hFF : io_do_q;
        end else begin
          M_DTACK_N <= 1'b0;
          if (IO_RNW) M_DO <= ev_timed ? 8'hFF : io_do_q;
        end
      end
      if (ev_release) begin
        M_DTACK_N <= 1'b1;
        Z_DTACK_N <= 1'b1;
      end
    end
  end

endmodule

// File: doc/gen_io_arb.md
GEN_IO_ARB -- requirements
Module: gen_io_arb

Interface
REQ-001 Parameter FIXED_PRIO, default 1, meaning: 1 = 68K always wins a tie; 0 = round-robin between 68K and Z80.
REQ-002 Parameter TMO, default 200, meaning: number of CE ticks to wait for slave DTACK before a forced completion.
REQ-003 CLK  in  1  system clock; one clock; all logic SHALL be clocked on its rising edge.
REQ-004 RESET  in  1  reset; synchronous, active-high.
REQ-005 CE  in  1  slave clock enable, the same CE the I/O slave uses; used only by the timeout counter.
REQ-006 M_SEL, M_A, M_RNW, M_DI  in  1,4,1,8  68K request: select, address A[4:1], read-not-write, write data.
REQ-007 M_DO, M_DTACK_N  out  8,1  68K read data; 68K acknowledge, active low.
REQ-008 Z_SEL, Z_A, Z_RNW, Z_DI  in  1,4,1,8  Z80 bank-window request, with the same meanings as M_*.
REQ-009 Z_DO, Z_DTACK_N  out  8,1  Z80 read data; Z80 acknowledge, active low.
REQ-010 IO_SEL, IO_A, IO_RNW, IO_DI  out  1,4,1,8  request driven to the shared I/O slave.
REQ-011 IO_DO, IO_DTACK_N  in  8,1  slave read data; slave acknowledge, active low.
REQ-012 TMO_ERR  out  1  one-CLK pulse on each forced (timed-out) completion.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, DONE and RECOVER; the reset state SHALL be IDLE.
REQ-014 In IDLE, with M_SEL or Z_SEL high, the block SHALL grant one requester and go to ACCESS on the next CLK.
- On grant, it SHALL latch that requester's A, RNW and DI into IO_A, IO_RNW, IO_DI and set IO_SEL=1.
REQ-015 Grant rule when only one SEL is high: that requester is granted.
- When both are high and FIXED_PRIO=1: 68K is granted.
- When both are high and FIXED_PRIO=0: the requester not granted last time is granted; the last-grant flag resets to "Z80", so 68K wins the first tie.
REQ-016 The latched IO_A, IO_RNW and IO_DI SHALL stay constant while IO_SEL=1, regardless of requester input changes.
REQ-017 In ACCESS, when IO_DTACK_N=0 is sampled, the block SHALL do all of the following on the next CLK, then go to DONE:
- set IO_SEL=0;
- copy IO_DO to the granted requester's DO (reads only; on writes, DO holds its previous value);
- drive the granted requester's DTACK_N=0.
REQ-018 Latency: requester SEL sampled in IDLE at edge N gives IO_SEL=1 after edge N+1; slave DTACK_N=0 sampled at edge K gives requester DTACK_N=0 after edge K+1.
REQ-019 In DONE, the requester's DTACK_N SHALL stay 0 until its SEL is sampled 0. Then, on the next CLK:
- DTACK_N SHALL be set to 1;
- the FSM SHALL go to RECOVER.
REQ-020 RECOVER SHALL return to IDLE at the first CLK on which IO_DTACK_N=1 is sampled, so a stale slave acknowledge is never reused.
REQ-021 Timeout: in ACCESS, an 8-bit counter cleared on grant SHALL count CE ticks and saturate at 255.
- When the count reaches TMO with IO_DTACK_N still 1, the block SHALL complete as in REQ-017 but with DO=0xFF (reads).
- It SHALL pulse TMO_ERR for one CLK.
REQ-022 Abort: if the granted requester's SEL drops while in ACCESS, the block SHALL set IO_SEL=0, leave that requester's DTACK_N at 1, and go to RECOVER; DO SHALL not update.
REQ-023 The non-granted requester SHALL see DTACK_N=1 throughout; its request stays pending and SHALL be evaluated in the next IDLE.
REQ-024 At most one requester DTACK_N SHALL be 0 at any time, and IO_SEL SHALL never be 1 outside ACCESS.

Reset
REQ-025 On RESET=1 at a CLK edge, the block SHALL set:
- IO_SEL=0, IO_A=0, IO_RNW=1, IO_DI=0;
- M_DTACK_N=1, Z_DTACK_N=1;
- M_DO=0xFF, Z_DO=0xFF;
- TMO_ERR=0, timeout counter=0, last-grant=Z80;
- FSM=IDLE.
REQ-026 RESET during any state, including mid-access, SHALL abandon the transaction with no acknowledge to either requester.

Verification
REQ-027 68K read: M_SEL=1, M_A=1, M_RNW=1; slave returns IO_DO=0x3F with DTACK after 2 CE -> IO_A=1, M_DO=0x3F, M_DTACK_N low one CLK after slave DTACK; Z untouched.
REQ-028 Simultaneous requests, FIXED_PRIO=0: M and Z both request three times back-to-back -> grants alternate M, Z, M; with FIXED_PRIO=1 -> M, M, M while Z stays pending (Z granted once M idles).
REQ-029 Z80 write: Z_A=4, Z_DI=0x40, Z_RNW=0 -> IO_DI=0x40 and IO_RNW=0 held stable until slave DTACK; Z_DO unchanged; Z_DTACK_N=0 until Z_SEL=0.
REQ-030 Timeout: slave never acknowledges, TMO=200 -> after 200 CE ticks, M_DO=0xFF, M_DTACK_N=0, TMO_ERR pulses exactly once.
REQ-031 Abort and stale acknowledge: M_SEL drops in ACCESS, then the slave holds DTACK_N=0 for 3 more CLK -> M_DTACK_N stays 1; FSM stays in RECOVER until DTACK_N=1; a pending Z request is then served correctly.
REQ-032 Reset mid-access: RESET pulse while IO_SEL=1 -> all outputs take their REQ-025 values on the next CLK; no DTACK is issued.
